seven_seg_scan_ctrl: RTL

// Time-multiplexes one shared seven_segments decoder across a 4-digit common-anode display.

---
 rtl/seven_seg_pkg.sv | 14 +
 rtl/refresh_tick_gen.sv | 24 ++
 rtl/seven_seg_scan_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types for the seven-segment scan controller
package seven_seg_pkg;
    localparam int N_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_e;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_cfg_t;
endpackage

// File: rtl/refresh_tick_gen.sv
// rtl/refresh_tick_gen.sv - free-running slot divider with a wrap tick on its last count
module refresh_tick_gen #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [$clog2(REFRESH_DIV)-1:0] div_cnt,
    output logic                           wrap
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    assign wrap = (div_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 4-digit multiplexed display scanner with frame-synchronous updates
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_i,
    input  logic        load_i,
    input  logic [3:0]  dp_en_i,
    input  logic [3:0]  digit_en_i,
    output logic [3:0]  hex_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic [1:0]  digit_idx_o,
    output logic        frame_done_o
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] div_cnt;
    logic          wrap;
    digit_idx_t    idx;
    scan_state_e   state;
    disp_cfg_t     shadow;
    disp_cfg_t     active;
    disp_cfg_t     in_cfg;
    logic          pending;
    logic          boundary;
    logic          in_blank;

    refresh_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .div_cnt (div_cnt),
        .wrap    (wrap)
    );

    assign in_cfg   = '{val: value_i, dp: dp_en_i, en: digit_en_i};
    assign boundary = wrap && (idx == digit_idx_t'(N_DIGITS - 1));
    // state tracks the phase of the current div_cnt, so outputs registered from it lag by one cycle
    assign in_blank = (state == ST_BLANK) && (BLANK_CYCLES != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            state        <= ST_BLANK;
            shadow       <= '0;
            active       <= '0;
            pending      <= 1'b0;
            hex_o        <= 4'h0;
            dp_o         <= 1'b1;
            an_o         <= 4'hF;
            digit_idx_o  <= 2'd0;
            frame_done_o <= 1'b0;
        end else begin
            if (load_i) begin
                shadow <= in_cfg;
            end
            // a load landing on the boundary itself bypasses the shadow
            if (boundary && load_i) begin
                active  <= in_cfg;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (load_i) begin
                pending <= 1'b1;
            end

            if (wrap) begin
                idx <= idx + 1'b1;
            end

            case (state)
                ST_BLANK: if (wrap) state <= (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                          else if (int'(div_cnt) >= BLANK_CYCLES - 1) state <= ST_DRIVE;
                ST_DRIVE: if (wrap) state <= (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                default:  state <= ST_BLANK;
            endcase

            hex_o        <= active.val[{idx, 2'b00} +: 4];
            digit_idx_o  <= idx;
            frame_done_o <= boundary;
            if (in_blank) begin
                an_o <= 4'hF;
                dp_o <= 1'b1;
            end else begin
                an_o <= active.en[idx] ? ~(4'b0001 << idx) : 4'hF;
                dp_o <= ~(active.dp[idx] & active.en[idx]);
            end
        end
    end
endmodule
